vga_pattern_stream_src: RTL and testbench

//  - Avalon-ST video source that feeds the VGA controller's pixel stream sink in the test VGA system.
//  - Generates frames of raster-ordered 24-bit RGB pixels (R[23:16], G[15:8], B[7:0]) with SOP/EOP framing.
//  - Four selectable test patterns; honours sink backpressure (ready); produces back-to-back frames while enabled.

---
 rtl/vga_pattern_pkg.sv | 21 ++
 rtl/vga_pattern_colour.sv | 49 ++++
 rtl/vga_pattern_stream_src.sv | 140 ++++++++++++++
 tb/tb_vga_pattern_stream_src.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared types and colour constants for the VGA test-pattern stream source.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  typedef logic [23:0] pixel_t;

  localparam pixel_t RGB_WHITE = 24'hFF_FFFF;
  localparam pixel_t RGB_BLACK = 24'h00_0000;

endpackage

// File: rtl/vga_pattern_colour.sv
// Combinational colour lookup: (pattern, x', y) -> 24-bit RGB.
module vga_pattern_colour
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  pattern_e        pattern,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  output pixel_t          rgb
);

  localparam int BAR_W = H_ACTIVE / BAR_COUNT;

  logic       cx;
  logic       cy;
  logic [2:0] bar_idx;
  logic [2:0] bar_rev;

  // Squares larger than the raster collapse to a single colour.
  if (CHECK_LOG2 < XW) begin : g_cx
    assign cx = x[CHECK_LOG2];
  end else begin : g_cx0
    assign cx = 1'b0;
  end
  if (CHECK_LOG2 < YW) begin : g_cy
    assign cy = y[CHECK_LOG2];
  end else begin : g_cy0
    assign cy = 1'b0;
  end

  always_comb begin
    bar_idx = 3'(x / XW'(BAR_W));
    bar_rev = 3'd7 - bar_idx;
    rgb     = RGB_WHITE;
    case (pattern)
      PAT_BARS:  rgb = {{8{bar_rev[2]}}, {8{bar_rev[1]}}, {8{bar_rev[0]}}};
      PAT_CHECK: rgb = (cx ^ cy) ? RGB_WHITE : RGB_BLACK;
      PAT_GRAD:  rgb = {8'(x), 8'(y), 8'(x) + 8'(y)};
      PAT_SOLID: rgb = RGB_WHITE;
      default:   rgb = RGB_WHITE;
    endcase
  end

endmodule

// File: rtl/vga_pattern_stream_src.sv
// Avalon-ST raster test-pattern source with SOP/EOP framing and backpressure.
// Optional VGA_PATTERN_SCROLL_EN: per-frame counter scrolls the image horizontally.
module vga_pattern_stream_src
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        frame_done
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  state_e        state;
  pattern_e      pat;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          accept;
  logic          restart;
  pattern_e      col_pat;
  logic [XW-1:0] col_x;
  logic [XW-1:0] col_xs;
  logic [YW-1:0] col_y;
  pixel_t        col_rgb;
`ifdef VGA_PATTERN_SCROLL_EN
  localparam int SW = XW + 9;
  logic [7:0]    frame_cnt;
  logic [7:0]    col_fc;
  logic [SW-1:0] x_sum;
`endif

  assign accept = out_valid & out_ready;

  // Select the coordinate of the beat that will be loaded on the next edge.
  always_comb begin
    nx      = (x == XW'(H_ACTIVE - 1)) ? '0 : x + XW'(1);
    ny      = (x == XW'(H_ACTIVE - 1)) ? ((y == YW'(V_ACTIVE - 1)) ? '0 : y + YW'(1)) : y;
    restart = (state == ST_IDLE) || (accept && out_endofpacket);
    col_pat = restart ? pattern_e'(pattern_sel) : pat;
    col_x   = restart ? '0 : nx;
    col_y   = restart ? '0 : ny;
`ifdef VGA_PATTERN_SCROLL_EN
    col_fc  = (state == ST_STREAM && accept && out_endofpacket) ? frame_cnt + 8'd1 : frame_cnt;
    x_sum   = SW'(col_x) + SW'(col_fc);
    col_xs  = XW'(x_sum % SW'(H_ACTIVE));
`else
    col_xs  = col_x;
`endif
  end

  vga_pattern_colour #(
    .H_ACTIVE   (H_ACTIVE),
    .BAR_COUNT  (BAR_COUNT),
    .CHECK_LOG2 (CHECK_LOG2),
    .XW         (XW),
    .YW         (YW)
  ) u_colour (
    .pattern (col_pat),
    .x       (col_xs),
    .y       (col_y),
    .rgb     (col_rgb)
  );

  // Output register stage: beat is held until accepted.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state             <= ST_IDLE;
      pat               <= PAT_BARS;
      x                 <= '0;
      y                 <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      frame_done        <= 1'b0;
`ifdef VGA_PATTERN_SCROLL_EN
      frame_cnt         <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            pat               <= col_pat;
            x                 <= '0;
            y                 <= '0;
            out_data          <= col_rgb;
            out_valid         <= 1'b1;
            out_startofpacket <= 1'b1;
            out_endofpacket   <= 1'b0;
            state             <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            x <= col_x;
            y <= col_y;
            if (out_endofpacket) begin
              frame_done <= 1'b1;
`ifdef VGA_PATTERN_SCROLL_EN
              frame_cnt  <= frame_cnt + 8'd1;
`endif
              if (enable) begin
                pat               <= col_pat;
                out_data          <= col_rgb;
                out_startofpacket <= 1'b1;
                out_endofpacket   <= 1'b0;
              end else begin
                out_valid         <= 1'b0;
                out_startofpacket <= 1'b0;
                out_endofpacket   <= 1'b0;
                state             <= ST_IDLE;
              end
            end else begin
              out_data          <= col_rgb;
              out_startofpacket <= 1'b0;
              out_endofpacket   <= (nx == XW'(H_ACTIVE - 1)) && (ny == YW'(V_ACTIVE - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pattern_stream_src.sv
// Directed bench for vga_pattern_stream_src on a reduced 64x36 raster.
module tb_vga_pattern_stream_src;

  localparam int H    = 64;
  localparam int V    = 36;
  localparam int NPIX = H * V;
`ifdef VGA_PATTERN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  sel;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sop;
  logic        eop;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [23:0] bufs [4][NPIX];
  int          sel_fc [4];

  typedef struct {
    int          sel;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t vt [12];

  vga_pattern_stream_src #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BAR_COUNT  (8),
    .CHECK_LOG2 (5)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .enable            (enable),
    .pattern_sel       (sel),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (sop),
    .out_endofpacket   (eop),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int s, input int x, input int y, input int fc);
    int xs;
    int i;
    xs = (x + SCROLL * fc) % H;
    case (s)
      0: begin
        i = 7 - ((xs / (H / 8)) % 8);
        return {((i & 4) != 0) ? 8'hFF : 8'h00, ((i & 2) != 0) ? 8'hFF : 8'h00,
                ((i & 1) != 0) ? 8'hFF : 8'h00};
      end
      1: return ((((xs >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(xs), 8'(y), 8'(xs + y)};
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Called at a negedge with beat 0 of a frame on the outputs; returns at the
  // negedge following the EOP accept.
  task automatic collect_frame(input int s, input int fc, input bit bp);
    int          beats = 0;
    int          cyc = 0;
    bit          pend = 0;
    logic [26:0] held = '0;
    bit          rdy;
    sel_fc[s] = fc;
    while (beats < NPIX && cyc < 4 * NPIX + 50) begin
      if (pend) chk("hold", {out_valid, sop, eop, out_data}, held);
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (!out_valid) begin
        chk("valid_in_frame", 32'(out_valid), 32'd1);
        pend = 0;
      end else if (rdy) begin
        chk("pix", out_data, exp_pix(s, beats % H, beats / H, fc));
        chk("sop", 32'(sop), 32'(beats == 0));
        chk("eop", 32'(eop), 32'(beats == NPIX - 1));
        bufs[s][beats] = out_data;
        beats++;
        pend = 0;
      end else begin
        pend = 1;
        held = {out_valid, sop, eop, out_data};
      end
      @(negedge clk);
      cyc++;
    end
    if (beats < NPIX) chk("frame_timeout", 32'(beats), 32'(NPIX));
  endtask

  task automatic chk_restart(input int s, input int fc);
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("no_bubble_valid", 32'(out_valid), 32'd1);
    chk("no_bubble_sop", 32'(sop), 32'd1);
    chk("next_frame_pix0", out_data, exp_pix(s, 0, 0, fc));
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    sel = 2'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 24'h0);
    chk("rst_sop", 32'(sop), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);

    enable = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_sop", 32'(sop), 32'd1);
    chk("first_data", out_data, 24'hFFFFFF);

    // Select changes right after SOP only take effect at the next frame.
    sel = 2'd1;
    collect_frame(0, 0, 1'b0);
    chk_restart(1, 1);
    sel = 2'd3;
    collect_frame(1, 1, 1'b1);
    chk_restart(3, 2);
    sel = 2'd2;
    collect_frame(3, 2, 1'b1);
    chk_restart(2, 3);
    enable = 1'b0;
    sel = 2'd0;
    collect_frame(2, 3, 1'b0);
    chk("last_fd", 32'(frame_done), 32'd1);
    chk("stop_valid", 32'(out_valid), 32'd0);
    chk("frame3_red", 32'(bufs[2][0][23:16]), 32'(SCROLL * 3));
    @(negedge clk);
    chk("fd_pulse_end", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("stay_idle", 32'(out_valid), 32'd0);

    vt[0]  = '{0,  0,  0, 24'hFFFFFF};
    vt[1]  = '{0,  8,  3, 24'hFFFF00};
    vt[2]  = '{0, 20,  5, 24'hFF00FF};
    vt[3]  = '{0, 30, 10, 24'hFF0000};
    vt[4]  = '{0, 63,  0, 24'h000000};
    vt[5]  = '{1, 32,  0, 24'hFFFFFF};
    vt[6]  = '{1, 32, 32, 24'h000000};
    vt[7]  = '{1,  0,  0, 24'h000000};
    vt[8]  = '{1,  0, 32, 24'hFFFFFF};
    vt[9]  = '{2, 10, 20, 24'h0A141E};
    vt[10] = '{2, 63, 35, 24'h3F2362};
    vt[11] = '{3,  5,  5, 24'hFFFFFF};
    for (int i = 0; i < 12; i++) begin
      int bx;
      bx = (vt[i].x - SCROLL * sel_fc[vt[i].sel] + 4 * H) % H;
      chk($sformatf("vec%0d", i), bufs[vt[i].sel][vt[i].y * H + bx], vt[i].exp);
    end

    // Abort a frame with reset at pixel (40,20).
    enable = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_sop", 32'(sop), 32'd1);
    for (int b = 0; b < 20 * H + 40; b++) @(negedge clk);
    chk("abort_pix", out_data, exp_pix(0, 40, 20, 4));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_data", out_data, 24'h0);
    chk("abort_eop", 32'(eop), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_sop", 32'(sop), 32'd1);
    enable = 1'b0;
    collect_frame(0, 0, 1'b1);
    chk("restart_fd", 32'(frame_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
